imem_fetch: RTL



---
 rtl/imem_fetch.sv | 91 +++++++++
 1 files changed

// File: rtl/imem_fetch.sv
// imem_fetch: drives the instruction RAM read port and turns its fixed-latency data into a valid/ready stream.
module imem_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_W = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [31:0]       ram_q,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
);
  localparam int DEPTH = RAM_LAT + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] pc_q, pc_d, fetch_pc;
  logic [RAM_LAT-1:0] tv_q, tv_d;
  logic [31:0] tpc_q [RAM_LAT];
  logic [31:0] tpc_d [RAM_LAT];
  logic [31:0] di_q [DEPTH];
  logic [31:0] di_d [DEPTH];
  logic [31:0] dp_q [DEPTH];
  logic [31:0] dp_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] used;
  logic pop, issue, ret;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    fetch_pc = redirect ? {redirect_pc[31:2], 2'b00} : pc_q;
    ram_address = rst_n ? fetch_pc[ADDR_W+1:2] : RESET_PC[ADDR_W+1:2];
    inst_valid = rst_n & (cnt_q != '0) & ~redirect;
    inst = rst_n ? di_q[rd_q] : '0;
    inst_pc = rst_n ? dp_q[rd_q] : '0;
    pop = inst_valid & inst_ready;
    used = {1'b0, cnt_q} - (CW+1)'(pop);
    for (int i = 0; i < RAM_LAT; i++) used = used + (CW+1)'(tv_q[i]);
    issue = rst_n & (redirect | (used < (CW+1)'(DEPTH)));
    ret = tv_q[RAM_LAT-1] & ~redirect;
    pc_d = issue ? fetch_pc + 32'd4 : pc_q;
    tv_d = '0;
    tpc_d = tpc_q;
    tv_d[0] = issue;
    tpc_d[0] = fetch_pc;
    for (int i = 1; i < RAM_LAT; i++) begin
      tv_d[i] = tv_q[i-1] & ~redirect;
      tpc_d[i] = tpc_q[i-1];
    end
    di_d = di_q;
    dp_d = dp_q;
    if (ret) begin
      di_d[wr_q] = ram_q;
      dp_d[wr_q] = tpc_q[RAM_LAT-1];
    end
    wr_d = redirect ? '0 : ret ? inc(wr_q) : wr_q;
    rd_d = redirect ? '0 : pop ? inc(rd_q) : rd_q;
    cnt_d = redirect ? '0 : cnt_q + CW'(ret) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      tv_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) tpc_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        di_q[i] <= '0;
        dp_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      tv_q <= tv_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RAM_LAT; i++) tpc_q[i] <= tpc_d[i];
      for (int i = 0; i < DEPTH; i++) begin
        di_q[i] <= di_d[i];
        dp_q[i] <= dp_d[i];
      end
    end
  end
endmodule
